// File: rtl/arm_cpu_pkg.sv
// Shared CPU definitions: register-file sizing defaults,
// the zero-register index and the register-address type.
package arm_cpu_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  localparam int ZERO_REG     = NUM_REGS_DEF - 1;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Decode/writeback bundle for the register file:
// operand reads, two writeback ports, load issue and status.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] read_address_1;
  logic [ADDR_W-1:0] read_address_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;

  logic              write_a_enable;
  logic [ADDR_W-1:0] write_a_address;
  logic [DATA_W-1:0] write_a_data;

  logic              write_b_enable;
  logic [ADDR_W-1:0] write_b_address;
  logic [DATA_W-1:0] write_b_data;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_address;

  logic              busy_1;
  logic              busy_2;
  logic              hazard;
  logic              scoreboard_error;

  modport master (
    output read_address_1, read_address_2,
    output write_a_enable, write_a_address,
    output write_a_data,
    output write_b_enable, write_b_address,
    output write_b_data,
    output issue_valid, issue_address,
    input  read_data_1, read_data_2,
    input  busy_1, busy_2, hazard,
    input  scoreboard_error
  );

  modport slave (
    input  read_address_1, read_address_2,
    input  write_a_enable, write_a_address,
    input  write_a_data,
    input  write_b_enable, write_b_address,
    input  write_b_data,
    input  issue_valid, issue_address,
    output read_data_1, read_data_2,
    output busy_1, busy_2, hazard,
    output scoreboard_error
  );

endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// Per-register busy bits for outstanding loads, with
// load-return bypass on lookup and a sticky misuse flag.
module reg_scoreboard
  import arm_cpu_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_address,
  input  logic              clear_valid,
  input  logic [ADDR_W-1:0] clear_address,
  input  logic [ADDR_W-1:0] read_address_1,
  input  logic [ADDR_W-1:0] read_address_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              scoreboard_error
);

  localparam logic [ADDR_W-1:0] ZERO_IDX =
    ADDR_W'(NUM_REGS - 1);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                err_hit;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return ZERO_REG_EN && (a == ZERO_IDX);
  endfunction

  // Set after clear so a same-cycle reissue stays pending
  always_comb begin
    busy_next = busy;
    if (clear_valid)
      busy_next[clear_address] = 1'b0;
    if (issue_valid && !is_zero(issue_address))
      busy_next[issue_address] = 1'b1;
  end

  assign err_hit = clear_valid
                 && !busy[clear_address]
                 && !is_zero(clear_address);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy             <= '0;
      scoreboard_error <= 1'b0;
    end else begin
      busy <= busy_next;
      if (err_hit)
        scoreboard_error <= 1'b1;
    end
  end

  assign busy_1 = busy[read_address_1]
    && !(clear_valid && clear_address == read_address_1)
    && !is_zero(read_address_1);

  assign busy_2 = busy[read_address_2]
    && !(clear_valid && clear_address == read_address_2)
    && !is_zero(read_address_2);

endmodule

// File: rtl/reg_file_scoreboard.sv
// Dual-writeback register bank with read bypass,
// hardwired zero register and load scoreboard.
module reg_file_scoreboard
  import arm_cpu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  reg_file_scoreboard_if.slave bus
);

  localparam logic [ADDR_W-1:0] ZERO_IDX =
    ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wa_ok;
  logic              wb_ok;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return ZERO_REG_EN && (a == ZERO_IDX);
  endfunction

  assign wa_ok = bus.write_a_enable
              && !is_zero(bus.write_a_address);
  assign wb_ok = bus.write_b_enable
              && !is_zero(bus.write_b_address);

  // Port A is written last: the ALU result is younger
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      if (wb_ok)
        regs[bus.write_b_address] <= bus.write_b_data;
      if (wa_ok)
        regs[bus.write_a_address] <= bus.write_a_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    if (is_zero(a))
      v = '0;
    else if (bus.write_a_enable && bus.write_a_address == a)
      v = bus.write_a_data;
    else if (bus.write_b_enable && bus.write_b_address == a)
      v = bus.write_b_data;
    else
      v = regs[a];
    return v;
  endfunction

  always_comb begin
    bus.read_data_1 = read_port(bus.read_address_1);
    bus.read_data_2 = read_port(bus.read_address_2);
  end

  logic busy_1;
  logic busy_2;
  logic sb_error;

  reg_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_sb (
    .clock            (clock),
    .reset_n          (reset_n),
    .issue_valid      (bus.issue_valid),
    .issue_address    (bus.issue_address),
    .clear_valid      (bus.write_b_enable),
    .clear_address    (bus.write_b_address),
    .read_address_1   (bus.read_address_1),
    .read_address_2   (bus.read_address_2),
    .busy_1           (busy_1),
    .busy_2           (busy_2),
    .scoreboard_error (sb_error)
  );

  assign bus.busy_1           = busy_1;
  assign bus.busy_2           = busy_2;
  assign bus.hazard           = busy_1 | busy_2;
  assign bus.scoreboard_error = sb_error;

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised successor to the CPU register bank. It has two write ports: port A for ALU writeback and port B for memory/load writeback. It also provides read-after-write bypass, a hardwired zero register, asynchronous clear, and a per-register busy scoreboard that flags operands still waiting on an outstanding load. It sits between decode (reads, issue) and the two writeback paths, and drives the pipeline stall request.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, ≥4)
- ADDR_W, $clog2(NUM_REGS), register address width
- ZERO_REG_EN, 1, when 1 register NUM_REGS-1 reads as zero and ignores writes and issue

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- read_address_1, read_address_2  in  ADDR_W  operand addresses
- read_data_1, read_data_2  out  DATA_W  operand values (combinational, bypassed)
- write_a_enable  in  1; write_a_address  in  ADDR_W; write_a_data  in  DATA_W  ALU writeback
- write_b_enable  in  1; write_b_address  in  ADDR_W; write_b_data  in  DATA_W  load writeback
- issue_valid  in  1; issue_address  in  ADDR_W  load issued; its destination becomes busy
- busy_1, busy_2  out  1  operand 1/2 still pending
- hazard  out  1  busy_1 | busy_2
- scoreboard_error  out  1  sticky: load writeback to a non-busy register

## Operation
- Reset: every register is 0, every busy bit is 0, and scoreboard_error is 0. This applies mid-operation too; in-flight writes in that cycle are discarded.
- Write: at the rising clock edge, an enabled port stores its data. If A and B target the same address in the same cycle, A wins (the ALU result belongs to the younger instruction).
- Read: returns the stored value, except the following bypass applies:
  - If a write port targets read_address_n this cycle, read_data_n returns that port's data.
  - When both ports match, A's data is returned, so the bypass matches the commit rule.
- Zero register (ZERO_REG_EN=1): reads of address NUM_REGS-1 return 0, including bypass cases. Writes to it and issues to it are ignored.
- Scoreboard:
  - issue_valid sets busy[issue_address] at the edge.
  - write_b_enable clears busy[write_b_address] at the edge.
  - If issue and clear target the same address in the same cycle, set wins (a new load is pending).
  - Port A never touches busy bits.
- busy_n = busy[read_address_n] & ~(write_b_enable & write_b_address == read_address_n). A load returning this cycle is bypassed, not stalled. busy_n is always 0 for the zero register.
- scoreboard_error is set when write_b_enable targets a register whose busy bit is 0, unless that register is the zero register. It stays set until reset.
- Issue to a register that is already busy: the bit stays 1 and this is not an error. A single clear frees the register.

## Timing
- Read path: zero-latency combinational from addresses and write ports to read_data, busy and hazard.
- Write latency: one edge. The value is in storage from the next cycle.
- Issue: busy is visible to readers in the cycle after issue_valid. In the issue cycle itself, a read of that address is not busy.
- scoreboard_error: asserts in the cycle after the offending write.
- Outputs during reset: read_data is 0 for non-bypassed reads, busy/hazard are 0, and scoreboard_error is 0.

## Structure
- Shared package arm_cpu_pkg: the DATA_W/NUM_REGS defaults, the ZERO_REG index constant, and the register-address typedef.
- One sub-module, reg_scoreboard, holds the NUM_REGS busy bits, the set/clear priority logic, the busy_n lookups and the sticky error flag.
- Storage, write arbitration and bypass muxes stay in the top module.

## Test plan
- Reset, then read all 32 addresses → all 0. Assert reset_n low mid-run after writing 0xDEAD to r5 → r5 reads 0 immediately.
- Write A r3=0x1111 and B r3=0x2222 in the same cycle → read r3 returns 0x1111 in that cycle (bypass) and in the next cycle (stored).
- Write 0xFFFF to r31, issue r31, read r31 → returns 0; busy stays 0; scoreboard_error stays 0.
- Issue r7; next cycle read r7 → busy_1=1, hazard=1. Then write B r7=0x42 → same cycle busy_1=0, read_data_1=0x42.
- Issue r9 and write B r9 in the same cycle (r9 previously busy) → next cycle busy for r9 is still 1, error stays 0.
- Write B r12 with r12 not busy → scoreboard_error=1 from the next cycle, held until reset_n low.
